// File: rtl/lorenz_plotter_if.sv
// rtl/lorenz_plotter_if.sv - pixel write bus between the Lorenz plotter and the framebuffer writer
interface lorenz_plotter_if;
  logic       pix_req;
  logic       pix_ack;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic [7:0] pix_color;

  modport master (output pix_req, output pix_x, output pix_y, output pix_color, input pix_ack);
  modport slave  (input pix_req, input pix_x, input pix_y, input pix_color, output pix_ack);
endinterface

// File: rtl/lorenz_plotter.sv
// rtl/lorenz_plotter.sv - paces the Lorenz solver and plots x/z and y/z panels to the framebuffer
// Optional feature macro: LORENZ_PLOT_CLEAR_EN (blank all 640x480 pixels after every reset).
module lorenz_plotter #(
  parameter int         WIDTH    = 27,
  parameter int         FRAC     = 20,
  parameter int         SCALE_SH = 2,
  parameter int         STEP_DIV = 1024,
  parameter int         ROW_BASE = 440,
  parameter logic [7:0] COLOR_A  = 8'hE0,
  parameter logic [7:0] COLOR_B  = 8'h1C
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic signed [WIDTH-1:0] z,
  output logic                    solver_step,
  lorenz_plotter_if.master        pix,
  output logic                    busy,
  output logic [31:0]             sample_count,
  output logic [15:0]             clip_count
);
  localparam int SH    = FRAC - SCALE_SH;
  localparam int PW    = WIDTH + 2;
  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(STEP_DIV - 1);

  // Screen limits widened to the projection width so clipping compares signed, before truncation.
  localparam logic signed [PW-1:0] L_0   = '0;
  localparam logic signed [PW-1:0] L_160 = PW'(160);
  localparam logic signed [PW-1:0] L_319 = PW'(319);
  localparam logic signed [PW-1:0] L_320 = PW'(320);
  localparam logic signed [PW-1:0] L_479 = PW'(479);
  localparam logic signed [PW-1:0] L_480 = PW'(480);
  localparam logic signed [PW-1:0] L_639 = PW'(639);
  localparam logic signed [PW-1:0] L_ROW = PW'(ROW_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_STEP,
    S_SAMPLE,
    S_PROJ,
    S_WR_A,
    S_WR_B
`ifdef LORENZ_PLOT_CLEAR_EN
    , S_CLEAR
`endif
  } state_t;

`ifdef LORENZ_PLOT_CLEAR_EN
  localparam state_t RESET_STATE = S_CLEAR;
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic                    step_q, step_d;
  logic                    req_q, req_d;
  logic [9:0]              pix_x_q, pix_x_d;
  logic [8:0]              pix_y_q, pix_y_d;
  logic [7:0]              pix_color_q, pix_color_d;
  logic signed [WIDTH-1:0] xs_q, xs_d, ys_q, ys_d, zs_q, zs_d;
  logic                    clip_a_q, clip_a_d, clip_b_q, clip_b_d;
  logic [9:0]              col_b_q, col_b_d;
  logic [8:0]              row_q, row_d;
  logic                    busy_q, busy_d;
  logic [31:0]             sample_count_q, sample_count_d;
  logic [15:0]             clip_count_q, clip_count_d;
  logic                    clip_inc;

  logic signed [WIDTH-1:0] sx, sy, sz;
  logic signed [PW-1:0]    col_a, col_b, row;
  logic                    row_out, clip_a, clip_b;

  // Project the registered sample onto both panels and decide clipping.
  always_comb begin
    sx      = xs_q >>> SH;
    sy      = ys_q >>> SH;
    sz      = zs_q >>> SH;
    col_a   = L_160 + PW'(sx);
    col_b   = L_480 + PW'(sy);
    row     = L_ROW - PW'(sz);
    row_out = (row < L_0) || (row > L_479);
    clip_a  = row_out || (col_a < L_0) || (col_a > L_319);
    clip_b  = row_out || (col_b < L_320) || (col_b > L_639);
  end

  // Next-state logic: step pacing, sampling, and the two-panel write handshake.
  always_comb begin
    state_d        = state_q;
    div_d          = div_q;
    step_d         = 1'b0;
    req_d          = req_q;
    pix_x_d        = pix_x_q;
    pix_y_d        = pix_y_q;
    pix_color_d    = pix_color_q;
    xs_d           = xs_q;
    ys_d           = ys_q;
    zs_d           = zs_q;
    clip_a_d       = clip_a_q;
    clip_b_d       = clip_b_q;
    col_b_d        = col_b_q;
    row_d          = row_q;
    sample_count_d = sample_count_q;
    clip_inc       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!run) begin
          state_d = S_IDLE;
          div_d   = DIV_RELOAD;
        end else if (div_q == '0) begin
          state_d = S_STEP;
          div_d   = DIV_RELOAD;
          step_d  = 1'b1;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      S_STEP: begin
        state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        xs_d           = x;
        ys_d           = y;
        zs_d           = z;
        sample_count_d = sample_count_q + 32'd1;
        state_d        = S_PROJ;
      end
      S_PROJ: begin
        // Panel A's request rises straight out of PROJ so an unclipped A costs no extra cycle.
        clip_a_d = clip_a;
        clip_b_d = clip_b;
        col_b_d  = col_b[9:0];
        row_d    = row[8:0];
        state_d  = S_WR_A;
        if (!clip_a) begin
          req_d       = 1'b1;
          pix_x_d     = col_a[9:0];
          pix_y_d     = row[8:0];
          pix_color_d = COLOR_A;
        end
      end
      S_WR_A: begin
        if (clip_a_q) begin
          // No A write happened, so B may request immediately without a low gap.
          clip_inc = 1'b1;
          state_d  = S_WR_B;
          if (!clip_b_q) begin
            req_d       = 1'b1;
            pix_x_d     = col_b_q;
            pix_y_d     = row_q;
            pix_color_d = COLOR_B;
          end
        end else if (pix.pix_ack) begin
          req_d   = 1'b0;
          state_d = S_WR_B;
        end
      end
      S_WR_B: begin
        if (clip_b_q) begin
          clip_inc = 1'b1;
          state_d  = run ? S_WAIT : S_IDLE;
        end else if (!req_q) begin
          // First WR_B cycle after an accepted A write: the mandatory req-low gap.
          req_d       = 1'b1;
          pix_x_d     = col_b_q;
          pix_y_d     = row_q;
          pix_color_d = COLOR_B;
        end else if (pix.pix_ack) begin
          req_d   = 1'b0;
          state_d = run ? S_WAIT : S_IDLE;
        end
      end
`ifdef LORENZ_PLOT_CLEAR_EN
      S_CLEAR: begin
        // Sweep position lives in the pixel address registers; x advances fastest.
        if (!req_q) begin
          req_d       = 1'b1;
          pix_color_d = 8'h00;
        end else if (pix.pix_ack) begin
          req_d = 1'b0;
          if (pix_x_q == 10'd639) begin
            pix_x_d = 10'd0;
            if (pix_y_q == 9'd479) state_d = S_IDLE;
            else                   pix_y_d = pix_y_q + 9'd1;
          end else begin
            pix_x_d = pix_x_q + 10'd1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    clip_count_d = clip_count_q;
    if (clip_inc && (clip_count_q != 16'hFFFF)) clip_count_d = clip_count_q + 16'd1;
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset wins in every state and drops any in-flight request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= RESET_STATE;
      div_q          <= DIV_RELOAD;
      step_q         <= 1'b0;
      req_q          <= 1'b0;
      pix_x_q        <= '0;
      pix_y_q        <= '0;
      pix_color_q    <= '0;
      xs_q           <= '0;
      ys_q           <= '0;
      zs_q           <= '0;
      clip_a_q       <= 1'b0;
      clip_b_q       <= 1'b0;
      col_b_q        <= '0;
      row_q          <= '0;
      busy_q         <= 1'b0;
      sample_count_q <= '0;
      clip_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      step_q         <= step_d;
      req_q          <= req_d;
      pix_x_q        <= pix_x_d;
      pix_y_q        <= pix_y_d;
      pix_color_q    <= pix_color_d;
      xs_q           <= xs_d;
      ys_q           <= ys_d;
      zs_q           <= zs_d;
      clip_a_q       <= clip_a_d;
      clip_b_q       <= clip_b_d;
      col_b_q        <= col_b_d;
      row_q          <= row_d;
      busy_q         <= busy_d;
      sample_count_q <= sample_count_d;
      clip_count_q   <= clip_count_d;
    end
  end

  assign solver_step   = step_q;
  assign pix.pix_req   = req_q;
  assign pix.pix_x     = pix_x_q;
  assign pix.pix_y     = pix_y_q;
  assign pix.pix_color = pix_color_q;
  assign busy          = busy_q;
  assign sample_count  = sample_count_q;
  assign clip_count    = clip_count_q;
endmodule

// File: tb/tb_lorenz_plotter.sv
// tb/tb_lorenz_plotter.sv - directed self-checking bench for lorenz_plotter
module tb_lorenz_plotter;
  logic               clk = 1'b0;
  logic               reset;
  logic               run;
  logic signed [26:0] x, y, z;
  logic               solver_step;
  logic               busy;
  logic [31:0]        sample_count;
  logic [15:0]        clip_count;

  lorenz_plotter_if pix_if ();

  lorenz_plotter #(.STEP_DIV(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .x            (x),
    .y            (y),
    .z            (z),
    .solver_step  (solver_step),
    .pix          (pix_if),
    .busy         (busy),
    .sample_count (sample_count),
    .clip_count   (clip_count)
  );

  always #5 clk = ~clk;

  int          passed = 0;
  int          total  = 0;
  int          step_cnt = 0;
  int          ack_mode = 2;   // 0: ack low, 1: ack one cycle after req, 2: ack tied high
  logic        req_seen = 1'b0;
  logic [26:0] wlog[$];

  // Writer model and monitor, on the falling edge: drives ack, logs accepted pixels, counts steps.
  always @(negedge clk) begin
    case (ack_mode)
      0:       pix_if.pix_ack = 1'b0;
      1:       pix_if.pix_ack = pix_if.pix_req && req_seen;
      default: pix_if.pix_ack = 1'b1;
    endcase
    req_seen = pix_if.pix_req;
    if (pix_if.pix_req && pix_if.pix_ack)
      wlog.push_back({pix_if.pix_x, pix_if.pix_y, pix_if.pix_color});
    if (solver_step) step_cnt++;
  end

  function automatic logic [31:0] pxl(input int px, input int py, input logic [7:0] c);
    logic [26:0] e;
    e = {10'(px), 9'(py), c};
    return 32'(e);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_log(input int n, input int limit);
    int i = 0;
    while (wlog.size() < n && i < limit) begin
      @(posedge clk); #1;
      i++;
    end
    chk("write_count", 32'(wlog.size()), 32'(n));
  endtask

  task automatic wait_req(input int limit);
    int i = 0;
    while (pix_if.pix_req !== 1'b1 && i < limit) begin
      @(posedge clk); #1;
      i++;
    end
    chk("req_rise", 32'(pix_if.pix_req), 32'd1);
  endtask

  initial begin
    int s0;
    int held;
    int i;
    reset = 1'b0; run = 1'b1; x = '0; y = '0; z = '0;

    // Reset held with run=1 and ack=1: everything quiet.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_step",   32'(solver_step),       32'd0);
    chk("rst_req",    32'(pix_if.pix_req),    32'd0);
    chk("rst_px",     32'(pix_if.pix_x),      32'd0);
    chk("rst_py",     32'(pix_if.pix_y),      32'd0);
    chk("rst_color",  32'(pix_if.pix_color),  32'd0);
    chk("rst_busy",   32'(busy),              32'd0);
    chk("rst_sample", sample_count,           32'd0);
    chk("rst_clip",   32'(clip_count),        32'd0);
    chk("rst_nostep", 32'(step_cnt),          32'd0);

    // Origin sample: step strobe exactly 4 clocks after WAIT entry.
    reset = 1'b1; ack_mode = 1;
    @(posedge clk); #1;
    chk("wait_busy", 32'(busy), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("step_early", 32'(solver_step), 32'd0);
    @(posedge clk); #1;
    chk("step_on", 32'(solver_step), 32'd1);
    @(posedge clk); #1;
    chk("step_off", 32'(solver_step), 32'd0);
    wait_log(2, 40);
    chk("origin_a", 32'(wlog[0]), pxl(160, 440, 8'hE0));
    chk("origin_b", 32'(wlog[1]), pxl(480, 440, 8'h1C));
    chk("origin_samples", sample_count, 32'd1);
    chk("origin_steps", 32'(step_cnt), 32'd1);

    // x=1.0, y=-1.0, z=25.0
    x = 27'h0100000; y = 27'h7F00000; z = 27'h1900000;
    wait_log(4, 40);
    chk("unit_a", 32'(wlog[2]), pxl(164, 340, 8'hE0));
    chk("unit_b", 32'(wlog[3]), pxl(476, 340, 8'h1C));
    chk("unit_samples", sample_count, 32'd2);

    // x=50.0 puts panel A at column 360: A clipped, B still written.
    x = 27'h3200000; y = '0; z = '0;
    wait_log(5, 40);
    chk("clipa_b", 32'(wlog[4]), pxl(480, 440, 8'h1C));
    chk("clipa_count", 32'(clip_count), 32'd1);

    // z=-20.0 puts the row at 520: both panels clipped, no writes.
    x = '0; z = 27'h6C00000;
    i = 0;
    while (sample_count != 32'd4 && i < 40) begin
      @(posedge clk); #1;
      i++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("cliprow_count", 32'(clip_count), 32'd3);
    chk("cliprow_nowrite", 32'(wlog.size()), 32'd5);

    // Panel edges: x=39.75 -> col 319, y=-40.0 -> col 320, z=-9.75 -> row 479.
    x = 27'h27C0000; y = 27'h5800000; z = 27'h7640000;
    wait_log(7, 40);
    chk("edge_a", 32'(wlog[5]), pxl(319, 479, 8'hE0));
    chk("edge_b", 32'(wlog[6]), pxl(320, 479, 8'h1C));
    chk("edge_clip", 32'(clip_count), 32'd3);

    // Writer stalls 50 clocks; run drops during the stall.
    x = 27'h0100000; y = 27'h7F00000; z = 27'h1900000;
    ack_mode = 0;
    wait_req(40);
    s0 = step_cnt;
    held = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (k == 10) run = 1'b0;
      if (pix_if.pix_req === 1'b1 && pix_if.pix_x === 10'd164 &&
          pix_if.pix_y === 9'd340 && pix_if.pix_color === 8'hE0) held++;
    end
    chk("stall_held", 32'(held), 32'd50);
    chk("stall_nostep", 32'(step_cnt), 32'(s0));
    ack_mode = 1;
    wait_log(9, 20);
    chk("stall_a", 32'(wlog[7]), pxl(164, 340, 8'hE0));
    chk("stall_b", 32'(wlog[8]), pxl(476, 340, 8'h1C));
    chk("stall_idle", 32'(busy), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("idle_nostep", 32'(step_cnt), 32'(s0));
    chk("idle_samples", sample_count, 32'd6);

    // Ack without a request is ignored.
    ack_mode = 2;
    repeat (5) @(posedge clk);
    #1;
    chk("ack_noreq_req", 32'(pix_if.pix_req), 32'd0);
    chk("ack_noreq_log", 32'(wlog.size()), 32'd9);

    // Reset while a request is in flight drops it at that edge with nothing pending.
    ack_mode = 0; run = 1'b1;
    wait_req(40);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rstfly_req",    32'(pix_if.pix_req), 32'd0);
    chk("rstfly_busy",   32'(busy),           32'd0);
    chk("rstfly_sample", sample_count,        32'd0);
    chk("rstfly_clip",   32'(clip_count),     32'd0);
    reset = 1'b1; run = 1'b0; ack_mode = 2;
    repeat (5) @(posedge clk);
    #1;
    chk("rstfly_nowrite", 32'(wlog.size()), 32'd9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
